sme_result_queue: RTL
=====================

# sme_result_queue

Result buffer directly downstream of the string-matching engine. Captures every per-job result pulse (valid, match, match_index) from the engine and tags it with a job sequence number. Holds results in a small show-ahead FIFO and presents them to the host through a valid/ready handshake. The engine has no back-pressure input, so this block absorbs bursts and reports any result it could not store.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- IDX_W, 5: match index width; equals the engine's string address width.
- SEQ_W, 8: job sequence number width.
- CNT_W, 16: statistics counter width (only when stats are compiled in).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  engine result strobe; one cycle per finished job.
- in_match  in  1  engine match flag, qualified by in_valid.
- in_match_index  in  IDX_W  engine match index, qualified by in_valid.
- out_valid  out  1  head entry available.
- out_ready  in  1  host accepts head entry.
- out_match  out  1  head entry match flag.
- out_match_index  out  IDX_W  head entry match index.
- out_seq  out  SEQ_W  head entry job sequence number.
- level  out  log2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; a result was dropped.
- clear_ovf  in  1  clears overflow.
- job_count  out  CNT_W  jobs seen (stats).
- match_count  out  CNT_W  matching jobs seen (stats).

## Operation
- Entry = {match, match_index, seq}. Storage is a circular buffer with wr_ptr, rd_ptr and a level counter.
- Job sequence counter seq_ctr:
  - increments on every in_valid, whether the result is stored or dropped;
  - wraps 2^SEQ_W-1 → 0;
  - the entry is tagged with the pre-increment value.
- A gap in out_seq tells the host that results were dropped.
- Push: in_valid && (!full || pop). Pop: out_valid && out_ready.
- Simultaneous push and pop: both take effect, level unchanged, including at full.
- Drop: in_valid && full && !pop. The entry is discarded and overflow is set.
- overflow stays 1 until clear_ovf or reset. clear_ovf in the same cycle as a drop leaves overflow at 1 (set wins).
- Pop while empty is impossible, because out_valid = 0 when empty; out_ready is ignored then.
- When in_valid = 0, in_match and in_match_index are don't-care and must not affect state.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.

## Timing
- All state is updated on the rising clk edge. Outputs are registered or derived from registered state only; there is no combinational path from in_* or out_ready to any output.
- Latency: in_valid at edge N → out_valid = 1 and head data valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Show-ahead: out_match, out_match_index and out_seq always reflect the head entry while out_valid = 1, and are held stable until the pop edge.
- Back-to-back: one push and one pop per cycle are sustainable indefinitely.
- Reset values: out_valid 0, out_match 0, out_match_index 0, out_seq 0, level 0, full 0, overflow 0, job_count 0, match_count 0. Pointers and seq_ctr are 0.
- Reset mid-operation flushes all entries. In_valid coincident with reset is discarded and not counted.

## Configuration
- SME_RESULT_STATS_EN defined:
  - job_count increments on every in_valid;
  - match_count increments on in_valid && in_match;
  - both saturate at 2^CNT_W-1 and clear only on reset.
- SME_RESULT_STATS_EN undefined:
  - counter logic is not built;
  - job_count and match_count are driven constant 0;
  - all other behaviour is identical.

## Test plan
- Single result: in_valid=1, in_match=1, in_match_index=7, out_ready=0 → next cycle out_valid=1, out_match=1, out_match_index=7, out_seq=0, level=1. Set out_ready=1 → level=0 one cycle later.
- Fill and overflow, DEPTH=4, out_ready=0: 5 pulses with indices 1..5 → full=1 after 4th, overflow=1 after 5th. Drain yields out_seq 0,1,2,3 and indices 1..4; next job is tagged seq 5.
- Push+pop at full: FIFO full, in_valid=1 and out_ready=1 in the same cycle → level stays 4, overflow stays 0, new entry appears last.
- clear_ovf: overflow=1, pulse clear_ovf → overflow=0. clear_ovf coincident with a drop → overflow=1.
- Sequence wrap: 256 accepted jobs with out_ready=1 → out_seq 255 followed by 0.
- Reset mid-stream with 3 entries queued: reset 1 cycle → out_valid=0, level=0, out_seq=0. With SME_RESULT_STATS_EN: 3 matches + 2 non-matches give job_count=5, match_count=3, and both read 0 after reset.

Source files
------------

// File: rtl/sme_result_queue_if.sv
// Handshake bundle between the string-matching engine, the result queue and
// the host. The queue itself attaches through the slave modport; the master
// modport is the engine and host side driving results in and taking them out.
interface sme_result_queue_if #(
  parameter int IDX_W = 5,
  parameter int SEQ_W = 8
);
  logic             in_valid;
  logic             in_match;
  logic [IDX_W-1:0] in_match_index;
  logic             out_valid;
  logic             out_ready;
  logic             out_match;
  logic [IDX_W-1:0] out_match_index;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output in_valid, in_match, in_match_index, out_ready,
    input  out_valid, out_match, out_match_index, out_seq
  );

  modport slave (
    input  in_valid, in_match, in_match_index, out_ready,
    output out_valid, out_match, out_match_index, out_seq
  );
endinterface

// File: rtl/sme_result_queue.sv
// Result buffer behind the string-matching engine. Every engine result pulse
// is tagged with a job sequence number and stored in a show-ahead circular
// FIFO read by the host over valid/ready. The engine cannot be stalled, so a
// result arriving while the FIFO is full (and not being popped) is dropped and
// a sticky overflow flag is raised; the gap in out_seq shows which job was lost.
//
// Optional statistics counters are built when SME_RESULT_STATS_EN is defined;
// otherwise job_count and match_count are tied to zero.
module sme_result_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  sme_result_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [CNT_W-1:0]           job_count,
  output logic [CNT_W-1:0]           match_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
  logic             ovf_q,    ovf_d;

  // Entry storage (data only, never reset)
  logic             mem_match_q [DEPTH];
  logic [IDX_W-1:0] mem_idx_q   [DEPTH];
  logic [SEQ_W-1:0] mem_seq_q   [DEPTH];

  logic out_valid_w;
  logic full_w;
  logic push;
  logic pop;
  logic drop;

  assign out_valid_w = (level_q != '0);
  assign full_w      = (level_q == LVL_W'(DEPTH));

  // Next-state logic: handshake decode, pointer/level/sequence/overflow update
  always_comb begin
    pop       = out_valid_w && bus.out_ready;
    push      = bus.in_valid && (!full_w || pop);
    drop      = bus.in_valid && full_w && !pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    seq_ctr_d = seq_ctr_q;
    ovf_d     = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Every result consumes a sequence number, stored or not
    if (bus.in_valid) seq_ctr_d = seq_ctr_q + SEQ_W'(1);
    // A drop in the same cycle as clear_ovf keeps the flag set
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      seq_ctr_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      seq_ctr_q <= seq_ctr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Entry write; tagged with the pre-increment sequence number
  always_ff @(posedge clk) begin
    if (push) begin
      mem_match_q[wr_ptr_q] <= bus.in_match;
      mem_idx_q[wr_ptr_q]   <= bus.in_match_index;
      mem_seq_q[wr_ptr_q]   <= seq_ctr_q;
    end
  end

  // Head entry shown directly from storage; forced to zero while empty so
  // the outputs read zero after reset regardless of stale storage contents
  assign bus.out_valid       = out_valid_w;
  assign bus.out_match       = out_valid_w & mem_match_q[rd_ptr_q];
  assign bus.out_match_index = out_valid_w ? mem_idx_q[rd_ptr_q] : '0;
  assign bus.out_seq         = out_valid_w ? mem_seq_q[rd_ptr_q] : '0;

  assign level    = level_q;
  assign full     = full_w;
  assign overflow = ovf_q;

`ifdef SME_RESULT_STATS_EN
  logic [CNT_W-1:0] job_cnt_q,   job_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating statistics: every job, and every matching job
  always_comb begin
    job_cnt_d   = job_cnt_q;
    match_cnt_d = match_cnt_q;
    if (bus.in_valid)                 job_cnt_d   = sat_inc(job_cnt_q);
    if (bus.in_valid && bus.in_match) match_cnt_d = sat_inc(match_cnt_q);
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      job_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      job_cnt_q   <= job_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign job_count   = job_cnt_q;
  assign match_count = match_cnt_q;
`else
  assign job_count   = '0;
  assign match_count = '0;
`endif

endmodule
